mac_array: RTL and testbench

Six-lane signed multiply-accumulate engine that produces the 32-bit `MAC_out_0..5` words consumed by the post-MAC bias/ReLU/shift stage. It sits between the operand fetch logic (activation and weight memories) and the post-MAC stage. It accepts a programmed number of operand beats per job over a valid/ready handshake. It then presents the six accumulated sums plus the layer tag under a second valid/ready handshake.

---
 rtl/mac_pkg.sv | 27 ++
 rtl/mac_lane.sv | 64 ++++++
 rtl/mac_array.sv | 158 +++++++++++++++
 tb/tb_mac_array.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ============================================================================
// Module  : mac_pkg
// Brief   : Shared layer encodings, width defaults and FSM states for the
//           MAC engine and the post-MAC stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam logic [1:0] LAYER_CONV1 = 2'b00;
    localparam logic [1:0] LAYER_CONV2 = 2'b01;
    localparam logic [1:0] LAYER_FC    = 2'b10;

    localparam int c_DATA_W = 16;
    localparam int c_ACC_W  = 32;
    localparam int c_TAP_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } mac_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_lane.sv
// ============================================================================
// Module  : mac_lane
// Brief   : One signed multiply-accumulate lane. The accumulator saturates
//           when MAC_SAT_EN is defined and wraps otherwise.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_lane
    import mac_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ACC_W  = c_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_act,
    input  logic signed [DATA_W-1:0] i_wgt,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_next;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_prod     = i_act * i_wgt;
    assign w_prod_ext = ACC_W'(w_prod);

`ifdef MAC_SAT_EN
    localparam logic [ACC_W-1:0] c_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] w_sum;

    // One guard bit: overflow whenever the two top bits disagree.
    always_comb begin
        w_sum  = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
        w_next = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            w_next = w_sum[ACC_W] ? c_MIN : c_MAX;
        end
    end
`else
    assign w_next = r_acc + w_prod_ext;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/mac_array.sv
// ============================================================================
// Module  : mac_array
// Brief   : Six-lane signed MAC engine with job FSM, tap counter and in/out
//           valid/ready handshakes. Optional saturation: MAC_SAT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_array
    import mac_pkg::*;
#(
    parameter int LANES  = 6,
    parameter int DATA_W = c_DATA_W,
    parameter int ACC_W  = c_ACC_W,
    parameter int TAP_W  = c_TAP_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               layer,
    input  logic [TAP_W-1:0]         num_taps,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] act_0,
    input  logic signed [DATA_W-1:0] act_1,
    input  logic signed [DATA_W-1:0] act_2,
    input  logic signed [DATA_W-1:0] act_3,
    input  logic signed [DATA_W-1:0] act_4,
    input  logic signed [DATA_W-1:0] act_5,
    input  logic signed [DATA_W-1:0] wgt_0,
    input  logic signed [DATA_W-1:0] wgt_1,
    input  logic signed [DATA_W-1:0] wgt_2,
    input  logic signed [DATA_W-1:0] wgt_3,
    input  logic signed [DATA_W-1:0] wgt_4,
    input  logic signed [DATA_W-1:0] wgt_5,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               mac_layer,
    output logic signed [ACC_W-1:0]  mac_out_0,
    output logic signed [ACC_W-1:0]  mac_out_1,
    output logic signed [ACC_W-1:0]  mac_out_2,
    output logic signed [ACC_W-1:0]  mac_out_3,
    output logic signed [ACC_W-1:0]  mac_out_4,
    output logic signed [ACC_W-1:0]  mac_out_5,
    output logic                     busy
);

    mac_state_t        r_state;
    mac_state_t        w_state_nxt;
    logic [TAP_W-1:0]  r_cnt;
    logic [TAP_W-1:0]  r_taps;
    logic [1:0]        r_layer;
    logic              w_clr;
    logic              w_beat;
    logic              w_last;

    logic signed [DATA_W-1:0] w_act [LANES];
    logic signed [DATA_W-1:0] w_wgt [LANES];
    logic signed [ACC_W-1:0]  w_acc [LANES];

    assign w_clr  = (r_state == ST_IDLE) && start;
    assign w_beat = (r_state == ST_ACC) && in_valid;
    assign w_last = w_beat && (r_cnt == (r_taps - TAP_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (num_taps == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                in_ready = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_taps  <= '0;
            r_layer <= LAYER_CONV1;
        end else if (w_clr) begin
            r_cnt   <= '0;
            r_taps  <= num_taps;
            r_layer <= layer;
        end else if (w_beat) begin
            r_cnt   <= r_cnt + TAP_W'(1);
        end
    end

    assign w_act[0] = act_0;
    assign w_act[1] = act_1;
    assign w_act[2] = act_2;
    assign w_act[3] = act_3;
    assign w_act[4] = act_4;
    assign w_act[5] = act_5;
    assign w_wgt[0] = wgt_0;
    assign w_wgt[1] = wgt_1;
    assign w_wgt[2] = wgt_2;
    assign w_wgt[3] = wgt_3;
    assign w_wgt[4] = wgt_4;
    assign w_wgt[5] = wgt_5;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            mac_lane #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk    (clk),
                .reset  (reset),
                .i_clr  (w_clr),
                .i_en   (w_beat),
                .i_act  (w_act[g]),
                .i_wgt  (w_wgt[g]),
                .o_acc  (w_acc[g])
            );
        end
    endgenerate

    // Accumulators clear only on start, so results persist through IDLE.
    assign mac_out_0 = w_acc[0];
    assign mac_out_1 = w_acc[1];
    assign mac_out_2 = w_acc[2];
    assign mac_out_3 = w_acc[3];
    assign mac_out_4 = w_acc[4];
    assign mac_out_5 = w_acc[5];
    assign mac_layer = r_layer;

endmodule

`default_nettype wire

// File: tb/tb_mac_array.sv
// ============================================================================
// Module  : tb_mac_array
// Brief   : Self-checking bench for mac_array (vector table, directed corner
//           sequences and randomized jobs against a sum-of-products model).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_array;
    import mac_pkg::*;

    localparam int N = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        layer;
    logic [9:0]        num_taps;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [1:0]        mac_layer;
    logic signed [15:0] act_v [N];
    logic signed [15:0] wgt_v [N];
    logic signed [31:0] mo    [N];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic signed [15:0] a [N];
        logic signed [15:0] w [N];
    } beat_t;

    typedef struct {
        logic [1:0]         lyr;
        int                 taps;
        logic signed [15:0] a;
        logic signed [15:0] w;
        logic [31:0]        exp;
    } vec_t;

    beat_t       beats [$];
    logic [31:0] res   [N];

    always #5 clk = ~clk;

    mac_array dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .layer     (layer),
        .num_taps  (num_taps),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_0     (act_v[0]),
        .act_1     (act_v[1]),
        .act_2     (act_v[2]),
        .act_3     (act_v[3]),
        .act_4     (act_v[4]),
        .act_5     (act_v[5]),
        .wgt_0     (wgt_v[0]),
        .wgt_1     (wgt_v[1]),
        .wgt_2     (wgt_v[2]),
        .wgt_3     (wgt_v[3]),
        .wgt_4     (wgt_v[4]),
        .wgt_5     (wgt_v[5]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mac_layer (mac_layer),
        .mac_out_0 (mo[0]),
        .mac_out_1 (mo[1]),
        .mac_out_2 (mo[2]),
        .mac_out_3 (mo[3]),
        .mac_out_4 (mo[4]),
        .mac_out_5 (mo[5]),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Sum of products per lane in wide integers, reduced to 32 bits each beat.
    function automatic logic [31:0] model_lane(input int lane);
        longint acc = 0;
        foreach (beats[k]) begin
            acc += longint'(beats[k].a[lane]) * longint'(beats[k].w[lane]);
`ifdef MAC_SAT_EN
            if (acc > 64'sh7FFFFFFF) acc = 64'sh7FFFFFFF;
            if (acc < -64'sh80000000) acc = -64'sh80000000;
`else
            acc = longint'(int'(acc));
`endif
        end
        return acc[31:0];
    endfunction

    task automatic fill_const(input int taps, input logic signed [15:0] a, input logic signed [15:0] w);
        beat_t b;
        beats.delete();
        for (int i = 0; i < N; i++) begin
            b.a[i] = a;
            b.w[i] = w;
        end
        for (int k = 0; k < taps; k++) beats.push_back(b);
    endtask

    task automatic fill_random(input int taps);
        beat_t b;
        beats.delete();
        for (int k = 0; k < taps; k++) begin
            for (int i = 0; i < N; i++) begin
                b.a[i] = 16'($urandom);
                b.w[i] = 16'($urandom);
            end
            beats.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge with the engine idle.
    task automatic run_job(input logic [1:0] lyr, input int taps, input int gap_pct,
                           input int bp, input bit spur, input string tag);
        int          idx;
        int          cyc;
        int          guard;
        bit          v;
        logic [31:0] exp [N];
        start    = 1'b1;
        layer    = lyr;
        num_taps = taps[9:0];
        tick();
        start = 1'b0;
        cyc   = 1;
        if (taps == 0) check({tag, "_zero_valid"}, {31'd0, out_valid}, 32'd1);
        else           check({tag, "_ready_c1"}, {30'd0, in_ready, busy}, 32'd3);
        idx   = 0;
        guard = 0;
        while (idx < taps && guard < taps * 20 + 200) begin
            v        = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            for (int i = 0; i < N; i++) begin
                act_v[i] = beats[idx].a[i];
                wgt_v[i] = beats[idx].w[i];
            end
            if (spur) begin
                start    = 1'b1;
                layer    = ~lyr;
                num_taps = 10'd1;
            end
            if (v && in_ready) idx++;
            tick();
            cyc++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        layer    = lyr;
        if (idx < taps) check({tag, "_beat_timeout"}, idx, taps);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        if (gap_pct == 0) check({tag, "_latency"}, cyc, (taps == 0) ? 1 : taps + 1);
        for (int i = 0; i < N; i++) begin
            exp[i] = model_lane(i);
            check($sformatf("%s_lane%0d", tag, i), mo[i], exp[i]);
            res[i] = mo[i];
        end
        check({tag, "_layer"}, {30'd0, mac_layer}, {30'd0, lyr});
        for (int c = 0; c < bp; c++) begin
            in_valid = 1'b1;
            act_v[0] = 16'($urandom);
            wgt_v[0] = 16'($urandom);
            tick();
            check({tag, "_bp_ctrl"}, {30'd0, out_valid, in_ready}, 32'd2);
            check({tag, "_bp_hold"}, mo[c % N], exp[c % N]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_ctrl"}, {30'd0, out_valid, busy}, 32'd0);
        check({tag, "_idle_hold"}, mo[0], exp[0]);
    endtask

    vec_t tbl [6];

    initial begin
        bit seen;
        tbl[0] = '{LAYER_CONV1, 25, 16'sd8, 16'sd3, 32'd600};
        tbl[1] = '{LAYER_FC, 1, -16'sd7, 16'sd9, 32'hFFFF_FFC1};
        tbl[2] = '{LAYER_CONV2, 3, 16'sd100, -16'sd200, 32'hFFFF_15A0};
        tbl[3] = '{LAYER_FC, 0, 16'sd5, 16'sd5, 32'd0};
`ifdef MAC_SAT_EN
        tbl[4] = '{LAYER_CONV1, 2, 16'sh8000, 16'sh8000, 32'h7FFF_FFFF};
        tbl[5] = '{2'b11, 3, 16'sh8000, 16'sh7FFF, 32'h8000_0000};
`else
        tbl[4] = '{LAYER_CONV1, 2, 16'sh8000, 16'sh8000, 32'h8000_0000};
        tbl[5] = '{2'b11, 3, 16'sh8000, 16'sh7FFF, 32'h4001_8000};
`endif

        reset     = 1'b1;
        start     = 1'b0;
        layer     = 2'b00;
        num_taps  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            act_v[i] = '0;
            wgt_v[i] = '0;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_ctrl", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'd0);
        check("rst_layer", {30'd0, mac_layer}, 32'd0);
        for (int i = 0; i < N; i++) check($sformatf("rst_out%0d", i), mo[i], 32'd0);

        for (int t = 0; t < 6; t++) begin
            fill_const(tbl[t].taps, tbl[t].a, tbl[t].w);
            run_job(tbl[t].lyr, tbl[t].taps, 0, 2, 1'b0, $sformatf("vec%0d", t));
            for (int i = 0; i < N; i++)
                check($sformatf("vec%0d_const%0d", t, i), res[i], tbl[t].exp);
        end

        // Gapped input with lane products -5, 7, -2, 1, then long back-pressure.
        beats.delete();
        fill_const(1, -16'sd5, 16'sd1);
        begin
            beat_t b;
            b = beats[0];
            for (int i = 0; i < N; i++) b.a[i] = 16'sd7;  beats.push_back(b);
            for (int i = 0; i < N; i++) b.a[i] = -16'sd2; beats.push_back(b);
            for (int i = 0; i < N; i++) b.a[i] = 16'sd1;  beats.push_back(b);
        end
        run_job(LAYER_CONV1, 4, 50, 10, 1'b0, "gaps");
        check("gaps_sum", res[3], 32'd1);

        fill_const(5, 16'sd2, 16'sd3);
        run_job(LAYER_CONV1, 5, 0, 1, 1'b1, "spur_start");

        // Reset after 10 of 25 beats: job abandoned, no result ever appears.
        start    = 1'b1;
        layer    = LAYER_FC;
        num_taps = 10'd25;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            act_v[i] = 16'sd8;
            wgt_v[i] = 16'sd3;
        end
        repeat (10) tick();
        reset = 1'b1;
        #2;
        check("midrst_async", {30'd0, busy, in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        check("midrst_out", mo[0], 32'd0);
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        in_valid = 1'b0;
        check("midrst_no_valid", {31'd0, seen}, 32'd0);
        fill_const(25, 16'sd8, 16'sd3);
        run_job(LAYER_CONV1, 25, 0, 0, 1'b0, "after_rst");
        check("after_rst_600", res[5], 32'd600);

        fill_random(7);
        run_job(LAYER_FC, 7, 0, 0, 1'b0, "b2b_fc");
        fill_random(9);
        run_job(LAYER_CONV2, 9, 0, 0, 1'b0, "b2b_conv2");

        for (int j = 0; j < 20; j++) begin
            int t;
            t = $urandom_range(40, 1);
            fill_random(t);
            run_job(2'($urandom), t, $urandom_range(60), $urandom_range(4), 1'b0,
                    $sformatf("rnd%0d", j));
        end

        fill_random(1023);
        run_job(LAYER_FC, 1023, 0, 1, 1'b0, "max_taps");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
